// File: rtl/uart_pkg.sv
//============================================================================
// Module  : uart_pkg
// Purpose : Shared UART definitions: frame state encoding, parity mode
//           constants and the parity-bit helper used by both transmit and
//           receive sides.
// Ports   : none (package)
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Even mode yields the XOR of the data bits, odd mode its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~^data;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
//============================================================================
// Module  : uart_tx_if
// Purpose : Byte handshake and serial line bundle between on-chip logic
//           (master) and the UART transmitter (slave).
// Signals : dataOut[7:0] byte to send, dataValid byte present,
//           dataReady transmitter idle, uart_tx serial line,
//           busy frame in progress, byteSent end-of-frame pulse
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_if;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       uart_tx;
  logic       busy;
  logic       byteSent;

  modport master (
    output dataOut, dataValid,
    input  dataReady, uart_tx, busy, byteSent
  );

  modport slave (
    input  dataOut, dataValid,
    output dataReady, uart_tx, busy, byteSent
  );
endinterface

`default_nettype wire

// File: rtl/uart_baud_counter.sv
//============================================================================
// Module  : uart_baud_counter
// Purpose : Bit-period timer. Counts 1..DELAY_FRAMES while enabled and
//           flags the last cycle of each bit period.
// Ports   : clk, rst (async, active-high)
//           clear   restart the period (count loads 1)
//           enable  advance the count
//           bitEnd  high in the final cycle of a bit period
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_baud_counter #(
  parameter int DELAY_FRAMES = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bitEnd
);

  localparam int              CW   = $clog2(DELAY_FRAMES + 1);
  localparam logic [CW-1:0]   LAST = CW'(DELAY_FRAMES);

  logic [CW-1:0] count;

  // Loading 1 on clear makes the first period exactly DELAY_FRAMES cycles
  // long when measured from the clearing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= CW'(1);
    else if (enable)
      count <= (count == LAST) ? CW'(1) : count + CW'(1);
  end

  assign bitEnd = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//============================================================================
// Module  : uart_tx
// Purpose : UART transmitter. Serialises one byte per handshake: start bit,
//           8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Ports   : clk, rst (async, active-high)
//           bus (uart_tx_if.slave): dataOut, dataValid in;
//           dataReady, uart_tx, busy, byteSent out
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx #(
  parameter int DELAY_FRAMES = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  import uart_pkg::*;

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_t state,      state_next;
  logic [7:0]  shift_reg,  shift_next;
  logic        parity_reg, parity_next;
  logic [2:0]  bit_idx,    bit_idx_next;
  logic        tx_reg,     tx_next;
  logic        sent_reg,   sent_next;
  logic        accept;
  logic        bit_end;

  uart_baud_counter #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state != ST_IDLE),
    .bitEnd (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      bit_idx    <= '0;
      tx_reg     <= 1'b1;
      sent_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      bit_idx    <= bit_idx_next;
      tx_reg     <= tx_next;
      sent_reg   <= sent_next;
    end
  end

  // tx_next is the level the line takes at the edge that ends the current
  // bit, so the registered line changes exactly on bit boundaries.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    bit_idx_next = bit_idx;
    tx_next      = tx_reg;
    sent_next    = 1'b0;
    accept       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.dataValid) begin
          accept       = 1'b1;
          shift_next   = bus.dataOut;
          parity_next  = parity_bit(bus.dataOut, PARITY);
          bit_idx_next = '0;
          tx_next      = 1'b0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_next    = shift_reg[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx_next = '0;
            if (PARITY != PARITY_NONE) begin
              tx_next    = parity_reg;
              state_next = ST_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_next      = 1'b1;
          bit_idx_next = '0;
          state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            bit_idx_next = '0;
            sent_next    = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.dataReady = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.uart_tx   = tx_reg;
  assign bus.byteSent  = sent_reg;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//============================================================================
// Module  : tb_uart_tx
// Purpose : Self-checking bench for uart_tx. Four transmitters share clk/rst
//           with DELAY_FRAMES=4: dut0 no parity/1 stop, dut1 even parity,
//           dut2 odd parity, dut3 no parity/2 stop. Expected line levels are
//           queued when a byte is offered and popped as the line is sampled.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;
  import uart_pkg::*;

  localparam int D = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] d_out [N];
  logic       dv    [N];
  logic       rdy   [N];
  logic       line  [N];
  logic       bsy   [N];
  logic       sent  [N];

  int vectors = 0;
  int errors  = 0;
  logic exp_q [$];

  function automatic int par_of(input int i);
    case (i)
      1:       return PARITY_EVEN;
      2:       return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

  function automatic int stp_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int i);
    return D * (10 + ((par_of(i) != 0) ? 1 : 0) + stp_of(i) - 1);
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_dut
    uart_tx_if bus ();
    assign bus.dataOut   = d_out[i];
    assign bus.dataValid = dv[i];
    assign rdy[i]        = bus.dataReady;
    assign line[i]       = bus.uart_tx;
    assign bsy[i]        = bus.busy;
    assign sent[i]       = bus.byteSent;

    uart_tx #(
      .DELAY_FRAMES (D),
      .PARITY       (par_of(i)),
      .STOP_BITS    (stp_of(i))
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // Expected line level for every bit of one frame.
  function automatic void push_frame(input int n, input logic [7:0] b);
    int ones;
    ones = $countones(b);
    exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
    if (par_of(n) == PARITY_EVEN) exp_q.push_back((ones % 2) == 1);
    if (par_of(n) == PARITY_ODD)  exp_q.push_back((ones % 2) == 0);
    for (int s = 0; s < stp_of(n); s++) exp_q.push_back(1'b1);
  endfunction

  // Offers a byte; returns at the falling edge just after the accept edge.
  task automatic accept(input int n, input logic [7:0] b, input bit hold);
    @(negedge clk);
    vectors++;
    if (rdy[n] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready dut%0d: dataReady=%b, required 1", n, rdy[n]);
    end
    d_out[n] = b;
    dv[n]    = 1'b1;
    push_frame(n, b);
    @(negedge clk);
    if (!hold) dv[n] = 1'b0;
  endtask

  // Consumes one frame from the scoreboard, starting in the cycle after the
  // accept edge and ending in the byteSent cycle.
  task automatic sb_frame(input int n, input string tag);
    int   f;
    int   rdy_low;
    int   sent_at;
    logic e;
    f       = frame_len(n);
    rdy_low = 0;
    sent_at = -1;
    for (int c = 0; c <= f; c++) begin
      if (c > 0) @(negedge clk);
      if (sent[n] === 1'b1 && sent_at < 0) sent_at = c;
      if (c < f) begin
        if (rdy[n] === 1'b0 && bsy[n] === 1'b1) rdy_low++;
        if ((c % D) == 0 || (c % D) == D - 1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s dut%0d cycle%0d: scoreboard empty, line=%b", tag, n, c, line[n]);
          end else begin
            e = ((c % D) == D - 1) ? exp_q.pop_front() : exp_q[0];
            if (line[n] !== e) begin
              errors++;
              $display("FAIL %s dut%0d bit%0d cycle%0d: line=%b, required %b",
                       tag, n, c / D, c, line[n], e);
            end
          end
        end
      end else begin
        vectors++;
        if ({line[n], rdy[n]} !== 2'b11) begin
          errors++;
          $display("FAIL %s_end dut%0d: line,dataReady=%b%b, required 11", tag, n, line[n], rdy[n]);
        end
      end
    end
    vectors++;
    if (rdy_low != f) begin
      errors++;
      $display("FAIL %s_busy_cycles dut%0d: %0d cycles, required %0d", tag, n, rdy_low, f);
    end
    vectors++;
    if (sent_at != f) begin
      errors++;
      $display("FAIL %s_byteSent_cycle dut%0d: cycle %0d, required %0d", tag, n, sent_at, f);
    end
  endtask

  task automatic test_reset();
    for (int n = 0; n < N; n++) begin
      d_out[n] = 8'h00;
      dv[n]    = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < N; n++) begin
      vectors++;
      if ({line[n], rdy[n], bsy[n], sent[n]} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_state dut%0d: tx,rdy,busy,sent=%b%b%b%b, required 1100",
                 n, line[n], rdy[n], bsy[n], sent[n]);
      end
    end
  endtask

  task automatic test_basic();
    accept(0, 8'hA5, 1'b0);
    sb_frame(0, "basic_a5");
  endtask

  task automatic test_parity();
    accept(1, 8'h07, 1'b0);
    sb_frame(1, "even_07");
    accept(2, 8'h07, 1'b0);
    sb_frame(2, "odd_07");
    @(negedge clk);
    vectors++;
    if (sent[2] !== 1'b0) begin
      errors++;
      $display("FAIL byteSent_width dut2: byteSent=%b, required 0", sent[2]);
    end
  endtask

  task automatic test_back_to_back();
    int   f;
    int   gap;
    int   k;
    logic hist [200];
    f = frame_len(3);
    accept(3, 8'h00, 1'b1);
    d_out[3] = 8'hFF;
    push_frame(3, 8'hFF);
    fork
      begin
        sb_frame(3, "b2b_first");
        @(negedge clk);
        dv[3] = 1'b0;
        sb_frame(3, "b2b_second");
      end
      begin
        for (int c = 0; c <= 2 * f + 1; c++) begin
          if (c > 0) @(negedge clk);
          hist[c] = line[3];
        end
      end
    join
    gap = 0;
    k   = 9 * D;
    while (k <= 2 * f + 1 && hist[k] === 1'b1) begin
      gap++;
      k++;
    end
    vectors++;
    if (gap != 9) begin
      errors++;
      $display("FAIL b2b_gap dut3: %0d high cycles, required 9", gap);
    end
  endtask

  task automatic test_ignore_busy();
    int f;
    f = frame_len(0);
    accept(0, 8'h55, 1'b0);
    fork
      sb_frame(0, "ignore_55");
      begin
        d_out[0] = 8'h3C;
        for (int c = 1; c < f - 3; c++) begin
          @(negedge clk);
          dv[0] = ~dv[0];
        end
        @(negedge clk);
        dv[0] = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    vectors++;
    if ({line[0], rdy[0]} !== 2'b11) begin
      errors++;
      $display("FAIL ignore_no_restart dut0: line,dataReady=%b%b, required 11", line[0], rdy[0]);
    end
  endtask

  task automatic test_reset_mid();
    int f;
    int sent_seen;
    int low_seen;
    f = frame_len(0);
    accept(0, 8'h81, 1'b0);
    repeat (2 * D + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({line[0], rdy[0], bsy[0], sent[0]} !== 4'b1100) begin
      errors++;
      $display("FAIL async_reset dut0: tx,rdy,busy,sent=%b%b%b%b, required 1100",
               line[0], rdy[0], bsy[0], sent[0]);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sent_seen = 0;
    low_seen  = 0;
    for (int c = 0; c < f + 4; c++) begin
      @(negedge clk);
      if (sent[0] !== 1'b0) sent_seen++;
      if (line[0] !== 1'b1) low_seen++;
    end
    vectors++;
    if (sent_seen != 0) begin
      errors++;
      $display("FAIL reset_no_byteSent dut0: %0d pulses, required 0", sent_seen);
    end
    vectors++;
    if (low_seen != 0) begin
      errors++;
      $display("FAIL reset_line_idle dut0: %0d low cycles, required 0", low_seen);
    end
    accept(0, 8'h81, 1'b0);
    sb_frame(0, "after_reset_81");
  endtask

  task automatic test_sweep();
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      accept(0, b, 1'b0);
      sb_frame(0, "sweep");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per handshake onto a single line: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits. Sits between on-chip logic and the board TX pin. It is the transmit-side counterpart of `uart_rx` and shares its `DELAY_FRAMES` bit-period convention, so both ends run at the same baud from the same clock.

## Interface
- `DELAY_FRAMES`, 868: clock cycles per bit (CLOCK_FREQUENCY / BAUD_RATE; 868 = 115200 baud at 100 MHz); must be ≥ 2.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `dataOut`  in  8  byte to send; sampled only on accept.
- `dataValid`  in  1  dataOut holds a byte to send.
- `dataReady`  out  1  transmitter can accept a byte; high only in IDLE.
- `uart_tx`  out  1  serial line, registered, idles high.
- `busy`  out  1  frame in progress (= !dataReady).
- `byteSent`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
- Accept: on any rising edge in IDLE with `dataValid`=1. Latch `dataOut` into the shift register. Compute the parity bit from the latched byte: even = XOR of bits; odd = its inverse. Reset the bit counter and bit index, then enter START.
- Each bit lasts exactly `DELAY_FRAMES` cycles. Bit counter runs 1..DELAY_FRAMES; at DELAY_FRAMES it wraps to 1 and the next bit starts.
- DATA: drive shift[0] and shift right at each bit end. After 8 bits (index 7 completes), go to PARITY or STOP.
- STOP: line high for `STOP_BITS` × `DELAY_FRAMES` cycles. At the end: pulse `byteSent`, return to IDLE.
- `dataValid` in a non-IDLE state is ignored; the input byte is not sampled.
- Counter width = $clog2(DELAY_FRAMES+1); no overflow at any legal parameter value.
- Reset values: `uart_tx`=1, `dataReady`=1, `busy`=0, `byteSent`=0, state=IDLE, counters=0.
- Reset mid-frame: the frame is aborted immediately (async) and the line returns high. No `byteSent` pulse. After reset deassertion, the first accept is possible on the next edge.

## Timing
- Accept edge = T. `uart_tx` falls at T and stays low through edge T+DELAY_FRAMES.
- Data bit k occupies edges T+(k+1)·D through T+(k+2)·D, where D=DELAY_FRAMES.
- Frame length F = D·(10 + (PARITY≠0) + (STOP_BITS−1)) cycles.
- `byteSent` is high for the single cycle after edge T+F; `dataReady` rises at the same edge.
- Back-to-back: with `dataValid` held high, the next accept is at edge T+F+1. The minimum idle-high gap between frames is therefore stop bits plus exactly 1 cycle.
- `dataReady` is decoded from the state register (no combinational path from `dataValid`).

## Structure
- Shared package `uart_pkg`:
  - state enum localparams (IDLE, START, DATA, PARITY, STOP)
  - parity mode constants PARITY_NONE/ODD/EVEN
  - a function returning the parity bit for (byte, mode), reused by a future parity-checking `uart_rx`.
- One natural sub-module, `uart_baud_counter`:
  - Parameterised by DELAY_FRAMES; inputs clear/enable; outputs a one-cycle `bitEnd` strobe.
  - Reusable by `uart_rx`.
- Top module holds the FSM, shift register, bit index and output register.

## Test plan
All scenarios use DELAY_FRAMES=4.
- Send 0xA5 with PARITY=0, STOP_BITS=1 → line per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. `byteSent` pulses 40 cycles after accept; `dataReady` is low for those 40 cycles.
- Send 0x07 with PARITY=2 → parity bit 1 and a 44-cycle frame. Same byte with PARITY=1 → parity bit 0.
- Hold `dataValid` high with 0x00 then 0xFF, STOP_BITS=2 → two frames of 44 cycles each. Line high for exactly 9 cycles between the first frame's last data bit and the second start bit.
- During a frame of 0x55, change `dataOut` to 0x3C and toggle `dataValid` → transmitted bits remain those of 0x55; no second frame starts until `dataReady`.
- Assert `rst` mid-data of 0x81 → `uart_tx`=1 within the same cycle (async). No `byteSent`. After release, `dataReady`=1 and a new 0x81 frame transmits correctly.
- Sweep random bytes through a `uart_rx` instance with the same DELAY_FRAMES and PARITY=0 → received `dataIn` matches sent bytes for 256 frames.
